// File: rtl/counter_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : counter_driver_if                                              |
// | Request handshake, counter control and status bundle for counter_driver.  |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface counter_driver_if;
    logic       req_valid;
    logic [3:0] req_start;
    logic [3:0] req_target;
    logic       req_ready;
    logic       clr;
    logic       enb;
    logic       modo;
    logic [3:0] data;
    logic [3:0] Q;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] steps;

    modport master (
        output req_valid, req_start, req_target, clr, Q,
        input  req_ready, enb, modo, data, busy, done, err, steps
    );

    modport slave (
        input  req_valid, req_start, req_target, clr, Q,
        output req_ready, enb, modo, data, busy, done, err, steps
    );
endinterface
`default_nettype wire

// File: rtl/counter_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : counter_driver                                                  |
// | Sequences an external 4-bit load/up counter from start to target value.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module counter_driver (
    input  wire logic       clk,
    input  wire logic       reset,
    counter_driver_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_COUNT = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_start;
    logic [3:0] r_target;
    logic [3:0] r_steps;
    // One bit wider than a legal count so the watchdog limit is representable.
    logic [4:0] r_step_cnt;
    logic       w_match;
    logic       w_enb;
    logic       w_modo;
    logic       w_accept;

    assign w_match  = (bus.Q == r_target);
    assign w_accept = (r_state == S_IDLE) && bus.req_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_start    <= 4'd0;
            r_target   <= 4'd0;
            r_step_cnt <= 5'd0;
            r_steps    <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_start    <= bus.req_start;
                r_target   <= bus.req_target;
                r_step_cnt <= 5'd0;
            end
            if ((r_state == S_COUNT) && w_enb) begin
                r_step_cnt <= r_step_cnt + 5'd1;
            end
            if ((r_state == S_COUNT) && w_match) begin
                r_steps <= r_step_cnt[3:0];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_enb  = 1'b0;
        w_modo = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_enb  = 1'b1;
                w_modo = 1'b1;
                w_next = S_COUNT;
            end
            S_COUNT: begin
                w_enb = !w_match;
                // A working counter always matches within 15 steps; the 16th miss is a fault.
                if (w_match) begin
                    w_next = S_DONE;
                end else if (r_step_cnt == 5'd15) begin
                    w_next = S_ERR;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            S_ERR: begin
                if (bus.clr) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.err       = (r_state == S_ERR);
    assign bus.enb       = w_enb;
    assign bus.modo      = w_modo;
    assign bus.data      = r_start;
    assign bus.steps     = r_steps;

endmodule
`default_nettype wire

// File: tb/tb_counter_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_counter_driver                                               |
// | Directed scoreboard bench for counter_driver with a behavioural counter.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_counter_driver;

    typedef struct {
        bit         is_err;
        logic [3:0] steps;
        int         cycle;
        int         enbs;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] q_model = 4'd0;
    bit         model_stuck = 1'b0;
    logic [3:0] last_steps = 4'd0;
    int         checks = 0;
    int         failures = 0;
    exp_t       sb[$];

    counter_driver_if bus ();

    counter_driver dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the external counter; reset deliberately not applied.
    always_ff @(posedge clk) begin
        if (!model_stuck && bus.enb) begin
            q_model <= bus.modo ? bus.data : q_model + 4'd1;
        end
    end
    assign bus.Q = q_model;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_start  = 4'd0;
        bus.req_target = 4'd0;
        bus.clr        = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        checks++; if ({bus.enb, bus.modo, bus.busy} !== 3'b000) begin failures++; $display("FAIL reset_enb_modo_busy: got %b want 000", {bus.enb, bus.modo, bus.busy}); end
        checks++; if ({bus.done, bus.err} !== 2'b00) begin failures++; $display("FAIL reset_done_err: got %b want 00", {bus.done, bus.err}); end
        checks++; if (bus.data !== 4'd0 || bus.steps !== 4'd0) begin failures++; $display("FAIL reset_data_steps: got data=%0d steps=%0d want 0 0", bus.data, bus.steps); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle: got ready=%b busy=%b want 1 0", bus.req_ready, bus.busy); end
    endtask

    task automatic run_req(input logic [3:0] s, input logic [3:0] t, input bit expect_err);
        exp_t       e;
        exp_t       got;
        logic [3:0] n;
        logic [3:0] qe;
        int         cyc;
        int         enb_cnt;
        int         k;
        bit         seen;
        n        = t - s;
        e.is_err = expect_err;
        e.steps  = expect_err ? last_steps : n;
        e.cycle  = expect_err ? 18 : 3 + int'(n);
        e.enbs   = expect_err ? 16 : int'(n);
        sb.push_back(e);
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL accept_ready s=%0d t=%0d: got %b want 1", s, t, bus.req_ready); end
        bus.req_valid  = 1'b1;
        bus.req_start  = s;
        bus.req_target = t;
        cyc = 0; enb_cnt = 0; k = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            bus.req_valid = 1'b0;
            if (cyc == 1) begin
                checks++; if ({bus.enb, bus.modo, bus.req_ready, bus.busy} !== 4'b1101) begin failures++; $display("FAIL load_ctrl: got enb/modo/ready/busy=%b want 1101", {bus.enb, bus.modo, bus.req_ready, bus.busy}); end
                checks++; if (bus.data !== s) begin failures++; $display("FAIL load_data: got %0d want %0d", bus.data, s); end
            end else if (bus.done || bus.err) begin
                seen = 1'b1;
                got  = sb.pop_front();
                checks++; if (cyc !== got.cycle) begin failures++; $display("FAIL end_cycle s=%0d t=%0d: got %0d want %0d", s, t, cyc, got.cycle); end
                checks++; if (bus.err !== got.is_err || bus.done !== !got.is_err) begin failures++; $display("FAIL end_kind: got done=%b err=%b want err=%b", bus.done, bus.err, got.is_err); end
                checks++; if (bus.steps !== got.steps) begin failures++; $display("FAIL end_steps: got %0d want %0d", bus.steps, got.steps); end
                checks++; if (enb_cnt !== got.enbs) begin failures++; $display("FAIL enb_cycles: got %0d want %0d", enb_cnt, got.enbs); end
                checks++; if ({bus.enb, bus.busy, bus.req_ready} !== 3'b010) begin failures++; $display("FAIL end_ctrl: got enb/busy/ready=%b want 010", {bus.enb, bus.busy, bus.req_ready}); end
                if (!got.is_err) begin
                    last_steps = got.steps;
                    @(negedge clk);
                    checks++; if (bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin failures++; $display("FAIL done_pulse: got done=%b ready=%b want 0 1", bus.done, bus.req_ready); end
                    checks++; if (bus.steps !== got.steps) begin failures++; $display("FAIL steps_hold: got %0d want %0d", bus.steps, got.steps); end
                end
            end else begin
                qe = s + 4'(k);
                if (!model_stuck) begin
                    checks++; if (bus.Q !== qe) begin failures++; $display("FAIL count_q k=%0d: got %0d want %0d", k, bus.Q, qe); end
                end
                checks++; if (bus.modo !== 1'b0) begin failures++; $display("FAIL count_modo: got %b want 0", bus.modo); end
                if (bus.enb === 1'b1) enb_cnt++;
                k++;
            end
        end
        if (!seen) begin
            failures++;
            $display("FAIL end_timeout s=%0d t=%0d: got no done/err want one", s, t);
            void'(sb.pop_front());
        end
    endtask

    task automatic test_basic();
        run_req(4'd3, 4'd7, 1'b0);
    endtask

    task automatic test_wrap();
        run_req(4'd14, 4'd2, 1'b0);
    endtask

    task automatic test_stuck();
        model_stuck = 1'b1;
        run_req(4'd0, 4'd9, 1'b1);
        repeat (2) @(negedge clk);
        checks++; if ({bus.err, bus.enb, bus.req_ready, bus.busy} !== 4'b1001) begin failures++; $display("FAIL err_hold: got err/enb/ready/busy=%b want 1001", {bus.err, bus.enb, bus.req_ready, bus.busy}); end
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        checks++; if ({bus.err, bus.req_ready, bus.busy} !== 3'b010) begin failures++; $display("FAIL clr_idle: got err/ready/busy=%b want 010", {bus.err, bus.req_ready, bus.busy}); end
        model_stuck = 1'b0;
    endtask

    task automatic test_equal();
        run_req(4'd5, 4'd5, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_req(4'd2, 4'd4, 1'b0);
        run_req(4'd9, 4'd1, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_start  = 4'd0;
        bus.req_target = 4'd15;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            bus.req_valid = (i == 3);
            if (i == 3) begin
                bus.req_start  = 4'd8;
                bus.req_target = 4'd8;
            end
        end
        checks++; if (bus.busy !== 1'b1 || bus.data !== 4'd0) begin failures++; $display("FAIL busy_ignore: got busy=%b data=%0d want 1 0", bus.busy, bus.data); end
        reset         = 1'b1;
        bus.req_valid = 1'b1;
        bus.clr       = 1'b1;
        @(negedge clk);
        checks++; if ({bus.enb, bus.modo, bus.busy, bus.err, bus.req_ready} !== 5'b00001) begin failures++; $display("FAIL mid_reset_idle: got enb/modo/busy/err/ready=%b want 00001", {bus.enb, bus.modo, bus.busy, bus.err, bus.req_ready}); end
        checks++; if (bus.steps !== 4'd0 || bus.data !== 4'd0) begin failures++; $display("FAIL mid_reset_regs: got steps=%0d data=%0d want 0 0", bus.steps, bus.data); end
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.clr       = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_stay: got busy=%b ready=%b want 0 1", bus.busy, bus.req_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stuck();
        test_equal();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
